// File: rtl/seg7_to_bin_capture.sv
`timescale 1ns/1ps
// Purpose: capture a two-digit seven-segment image, decode it to BCD, flag illegal codes, convert BCD to 7-bit binary.
// Latency: out_valid rises 8 edges after accept for a legal pair, 1 edge after accept for an illegal pair.
// Backpressure: one pair in flight; in_ready only in IDLE, result held in DONE until out_ready.
module seg7_to_bin_capture #(
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit ALLOW_BLANK_TENS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_tens,
  input  logic [6:0] seg_ones,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] bin,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, DECODE, CONVERT, DONE} state_t;

  state_t     state;
  logic [6:0] cap_tens;
  logic [6:0] cap_ones;
  logic [7:0] bcd_sr;
  logic [6:0] acc;
  logic [2:0] iter;
  logic [3:0] dig_tens;
  logic [3:0] dig_ones;

  // Map an active-low segment code to {legal, digit}; unknown codes give {0, 0}.
  function automatic logic [4:0] decode_al(input logic [6:0] code);
    logic [4:0] r;
    case (code)
      7'b1000000: r = {1'b1, 4'd0};
      7'b1111001: r = {1'b1, 4'd1};
      7'b0100100: r = {1'b1, 4'd2};
      7'b0110000: r = {1'b1, 4'd3};
      7'b0011001: r = {1'b1, 4'd4};
      7'b0010010: r = {1'b1, 4'd5};
      7'b0000010: r = {1'b1, 4'd6};
      7'b1111000: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0010000: r = {1'b1, 4'd9};
      default:    r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // Normalise captured codes to active-low so one decode table serves both polarities.
  logic [6:0] norm_tens;
  logic [6:0] norm_ones;
  assign norm_tens = SEG_ACTIVE_LOW ? cap_tens : ~cap_tens;
  assign norm_ones = SEG_ACTIVE_LOW ? cap_ones : ~cap_ones;

  logic [4:0] dec_tens;
  logic [4:0] dec_ones;
  logic       tens_blank;
  logic       tens_ok;
  logic       ones_ok;
  assign dec_tens   = decode_al(norm_tens);
  assign dec_ones   = decode_al(norm_ones);
  assign tens_blank = (norm_tens == 7'b1111111);
  // A blank tens digit decodes to 0 (the table default) when it is allowed.
  assign tens_ok    = dec_tens[4] | (ALLOW_BLANK_TENS & tens_blank);
  // Blank never matches the table, so it is always illegal on the ones digit.
  assign ones_ok    = dec_ones[4];

  // One reverse double-dabble step: shift {bcd, acc} right, then pull back any nibble that reached 8+.
  logic [14:0] shifted;
  logic [3:0]  sh_hi;
  logic [3:0]  sh_lo;
  logic [7:0]  step_bcd;
  logic [6:0]  step_acc;
  assign shifted  = {1'b0, bcd_sr, acc[6:1]};
  assign sh_hi    = shifted[14:11];
  assign sh_lo    = shifted[10:7];
  assign step_acc = shifted[6:0];
  assign step_bcd = {(sh_hi >= 4'd8) ? (sh_hi - 4'd3) : sh_hi,
                     (sh_lo >= 4'd8) ? (sh_lo - 4'd3) : sh_lo};

  // Control FSM with registered handshake flags and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bin       <= 7'd0;
      bcd_tens  <= 4'd0;
      bcd_ones  <= 4'd0;
      error     <= 1'b0;
      cap_tens  <= 7'd0;
      cap_ones  <= 7'd0;
      bcd_sr    <= 8'd0;
      acc       <= 7'd0;
      iter      <= 3'd0;
      dig_tens  <= 4'd0;
      dig_ones  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cap_tens <= seg_tens;
            cap_ones <= seg_ones;
            in_ready <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (!(tens_ok && ones_ok)) begin
            error     <= 1'b1;
            bin       <= 7'd0;
            bcd_tens  <= 4'd0;
            bcd_ones  <= 4'd0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            dig_tens <= dec_tens[3:0];
            dig_ones <= dec_ones[3:0];
            bcd_sr   <= {dec_tens[3:0], dec_ones[3:0]};
            acc      <= 7'd0;
            iter     <= 3'd0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_sr <= step_bcd;
          acc    <= step_acc;
          iter   <= iter + 3'd1;
          // The seventh shift has just brought the last binary bit into acc.
          if (iter == 3'd6) begin
            bin       <= step_acc;
            bcd_tens  <= dig_tens;
            bcd_ones  <= dig_ones;
            error     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seg7_to_bin_capture.md
Name: seg7_to_bin_capture

Overview:
- Reverse direction of the BCD adder/display path: accepts a two-digit seven-segment display image (tens and ones codes) and decodes each code back to a BCD digit.
- Flags any code that is not a legal digit.
- Converts the validated two-digit BCD value to 7-bit binary with a multi-cycle reverse double-dabble.
- Sits between a display-pattern source (the adder outputs or a bench driver) and binary consumers; valid/ready handshake on both sides.

Parameters:
SEG_ACTIVE_LOW, 1, 1: segment inputs are active-low (digit '0' = 7'b1000000); 0: inputs are inverted before decode.
ALLOW_BLANK_TENS, 1, 1: all-segments-off tens code is accepted as digit 0; 0: it is an error.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
seg_tens  input  7  tens digit pattern, bit order {g,f,e,d,c,b,a}
seg_ones  input  7  ones digit pattern, same order
in_valid  input  1  segment pair is valid
in_ready  output  1  block can accept a pair; high only in IDLE
out_valid  output  1  result is valid; held until out_ready
out_ready  input  1  consumer takes the result
bin  output  7  binary value 0..99
bcd_tens  output  4  decoded tens digit
bcd_ones  output  4  decoded ones digit
error  output  1  illegal pattern in the captured pair

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; out_valid=0, bin=0, bcd_tens=0, bcd_ones=0, error=0; in_ready=1 in the first cycle after reset. Any operation in progress is discarded and no output is produced for it.
- Active-low legal codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Every other code is illegal, except blank 1111111 on tens when ALLOW_BLANK_TENS=1.
  - Blank is always illegal on ones.
- States: IDLE, DECODE, CONVERT, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, both codes are registered and the next state is DECODE. Otherwise the state stays IDLE.
- DECODE (1 cycle): decode both registered codes.
  - Any illegal code: error=1, bin=0, bcd_tens=0, bcd_ones=0, next state DONE.
  - Otherwise: load the 8-bit BCD shift register {tens,ones}, clear the binary accumulator, set iteration counter=0, next state CONVERT.
- CONVERT (exactly 7 cycles): each cycle, shift {bcd,acc} right by 1. Then in each BCD nibble whose value is >=8, subtract 3. Counter increments; after the 7th shift, bin=acc, bcd_tens and bcd_ones = decoded digits, error=0, next state DONE.
- DONE: out_valid=1.
  - bin, bcd_tens, bcd_ones and error are stable while out_valid=1.
  - On out_ready=1 the next state is IDLE and out_valid falls at that edge.
  - in_ready stays 0 during DONE, including the handshake cycle; there is no bypass.
- Latency:
  - Legal pair: out_valid rises at the 8th rising edge after the accept edge.
  - Illegal pair: out_valid rises at the 1st edge after the accept edge.
  - Minimum throughput: one pair per 10 cycles, or per 3 cycles on error.
- Outputs hold the last result after returning to IDLE until the next DONE overwrites them.
- in_valid or code changes outside IDLE are ignored. The captured values are immune to input changes after acceptance.
- out_ready asserted outside DONE has no effect.
- Width: bin is 7 bits, maximum 99 = 7'b1100011. No overflow is possible from legal inputs.

Test Plan:
- Reset, then seg_tens=0011001 ('4'), seg_ones=1111000 ('7'), in_valid pulse, out_ready=1 → out_valid 8 edges after accept, bin=47 (0101111), bcd_tens=4, bcd_ones=7, error=0, in_ready=1 the cycle after the handshake.
- '9','9' (0010000, 0010000) → bin=99 (1100011). Then '0','0' → bin=0, error=0.
- seg_ones=1111111 with tens '3' → out_valid 1 edge after accept, error=1, bin=0. Tens=1111111 with ones '5' (0010010) → bin=5, error=0 (ALLOW_BLANK_TENS=1); error=1 when ALLOW_BLANK_TENS=0.
- Illegal code 1010101 on tens → error=1. The next legal pair '1','2' → error=0, bin=12.
- Backpressure: hold out_ready=0 for 20 cycles after '6','3' → out_valid stays 1, bin=63 stable, in_ready=0, a second in_valid pulse is ignored; releasing out_ready completes one transaction only.
- Assert rst_n=0 for 1 cycle during CONVERT of '8','8' → next cycle IDLE, out_valid=0, bin=0, in_ready=1, no result emitted. SEG_ACTIVE_LOW=0 run with inverted codes reproduces scenario 1.
